// File: rtl/stream_checker.sv
// Self-checking stream sink: regenerates expected words with a seeded Galois LFSR,
// checks data and in_last framing, throttles in_ready and runs an inactivity watchdog.
// Optional macro STREAM_CHECKER_DISPLAY_EN adds $display reporting of errors and results.
module stream_checker #(
   parameter int unsigned DATA_W       = 32,
   parameter int unsigned NUM_WORDS    = 256,
   parameter logic [31:0] SEED         = 32'hACE1_0001,
   parameter int unsigned STALL_PERIOD = 0,
   parameter int unsigned TIMEOUT      = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_last,
   output logic              in_ready,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic [15:0]       err_cnt,
   output logic [15:0]       word_cnt,
   output logic [15:0]       first_err_idx,
   output logic [DATA_W-1:0] first_err_data
);

   localparam logic [31:0] POLY         = 32'h8020_0003;
   localparam logic [15:0] LAST_IDX     = 16'(NUM_WORDS - 1);
   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);
   localparam int unsigned SC_W         = (STALL_PERIOD >= 2) ? $clog2(STALL_PERIOD) : 1;
   localparam logic [SC_W-1:0] STALL_LAST = SC_W'((STALL_PERIOD >= 2) ? STALL_PERIOD - 1 : 0);
   localparam bit          STALL_EN     = (STALL_PERIOD >= 2);

   typedef enum logic [1:0] {IDLE, RUN, DONE, FAIL} state_t;

   state_t          state, state_next;
   logic [31:0]     lfsr, lfsr_next, idle_cnt;
   logic [SC_W-1:0] stall_cnt;
   logic            stall, xfer, data_err, frame_err, word_err, last_word, launch;

   assign launch    = start && (state != RUN);
   assign stall     = STALL_EN && (stall_cnt == STALL_LAST);
   assign in_ready  = (state == RUN) && !stall;
   assign busy      = (state == RUN);
   assign xfer      = in_valid && in_ready;
   assign last_word = (word_cnt == LAST_IDX);
   assign data_err  = (in_data != lfsr[DATA_W-1:0]);
   assign frame_err = (in_last != last_word);
   assign word_err  = xfer && (data_err || frame_err);
   assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ POLY) : (lfsr >> 1);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // A final transfer beats a coinciding watchdog expiry.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, DONE, FAIL: if (start) state_next = RUN;
         RUN: begin
            if (xfer && last_word)                         state_next = DONE;
            else if (!xfer && (idle_cnt == TIMEOUT_LAST))  state_next = FAIL;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfsr           <= '0;
         idle_cnt       <= '0;
         stall_cnt      <= '0;
         word_cnt       <= '0;
         err_cnt        <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
      end else if (launch) begin
         lfsr           <= SEED;
         idle_cnt       <= '0;
         stall_cnt      <= '0;
         word_cnt       <= '0;
         err_cnt        <= '0;
         first_err_idx  <= '0;
         first_err_data <= '0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
      end else if (state == RUN) begin
         if (STALL_EN) stall_cnt <= stall ? '0 : stall_cnt + 1'b1;
         if (xfer) begin
            lfsr     <= lfsr_next;
            word_cnt <= word_cnt + 16'd1;
            idle_cnt <= '0;
            if (word_err) begin
               if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
               // err_cnt saturates and never wraps, so zero means no error yet.
               if (err_cnt == 16'd0) begin
                  first_err_idx  <= word_cnt;
                  first_err_data <= in_data;
               end
            end
            if (last_word) begin
               done <= 1'b1;
               pass <= (err_cnt == 16'd0) && !word_err;
            end
         end else begin
            idle_cnt <= idle_cnt + 32'd1;
            if (idle_cnt == TIMEOUT_LAST) begin
               timeout <= 1'b1;
               done    <= 1'b1;
               pass    <= 1'b0;
            end
         end
      end
   end

`ifdef STREAM_CHECKER_DISPLAY_EN
   always @(posedge clk) begin
      if (!rst && (state == RUN)) begin
         if (word_err)
            $display("stream_checker: error at word %0d expected %h received %h",
                     word_cnt, lfsr[DATA_W-1:0], in_data);
         if (state_next == DONE)
            $display("stream_checker: done, words=%0d errors=%0d",
                     word_cnt + 16'd1, (err_cnt == 16'hFFFF || !word_err) ? err_cnt : err_cnt + 16'd1);
         else if (state_next == FAIL)
            $display("stream_checker: watchdog expired after %0d words, errors=%0d",
                     word_cnt, err_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_stream_checker.sv
// Directed bench for stream_checker: dut_a has no back-pressure, dut_b stalls 1 cycle in 4.
// Both use 8 words and a 20-cycle watchdog; they share the source stream but not start.
module tb_stream_checker;

   localparam logic [31:0] SEED = 32'hACE1_0001;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0, start_b = 1'b0;
   logic        in_valid = 1'b0, in_last = 1'b0;
   logic [31:0] in_data = '0;

   logic        a_ready, a_busy, a_done, a_pass, a_timeout;
   logic [15:0] a_err_cnt, a_word_cnt, a_first_idx;
   logic [31:0] a_first_data;
   logic        b_ready, b_busy, b_done, b_pass, b_timeout;
   logic [15:0] b_err_cnt, b_word_cnt, b_first_idx;
   logic [31:0] b_first_data;

   logic [31:0] exp_q[$];
   logic [31:0] sent[8];
   int          checks = 0;
   int          errors = 0;

   stream_checker #(.DATA_W(32), .NUM_WORDS(8), .SEED(SEED), .STALL_PERIOD(0), .TIMEOUT(20)) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(a_ready), .busy(a_busy), .done(a_done), .pass(a_pass),
      .timeout(a_timeout), .err_cnt(a_err_cnt), .word_cnt(a_word_cnt),
      .first_err_idx(a_first_idx), .first_err_data(a_first_data)
   );

   stream_checker #(.DATA_W(32), .NUM_WORDS(8), .SEED(SEED), .STALL_PERIOD(4), .TIMEOUT(20)) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .in_valid(in_valid), .in_data(in_data),
      .in_last(in_last), .in_ready(b_ready), .busy(b_busy), .done(b_done), .pass(b_pass),
      .timeout(b_timeout), .err_cnt(b_err_cnt), .word_cnt(b_word_cnt),
      .first_err_idx(b_first_idx), .first_err_data(b_first_data)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [31:0] lfsr_step(input logic [31:0] v);
      return v[0] ? ((v >> 1) ^ 32'h8020_0003) : (v >> 1);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic fill_q();
      logic [31:0] v;
      exp_q.delete();
      v = SEED;
      for (int i = 0; i < 8; i++) begin
         exp_q.push_back(v);
         v = lfsr_step(v);
      end
   endtask

   task automatic pulse_start(input int sel);
      if (sel == 0) start_a = 1'b1;
      else          start_b = 1'b1;
      @(posedge clk); #1;
      start_a = 1'b0;
      start_b = 1'b0;
   endtask

   // Presents one word to dut_a and returns #1 after the edge that accepts it.
   task automatic send_word(input logic [31:0] d, input logic l);
      int n;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      n = 0;
      while (!a_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      check("a_ready_when_sent", 32'(a_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Sends n_words of the expected sequence; word corrupt_idx is XORed with mask.
   task automatic run_stream(input int n_words, input int corrupt_idx,
                             input logic [31:0] mask, input int last_idx);
      fill_q();
      for (int i = 0; i < n_words; i++) begin
         sent[i] = exp_q.pop_front();
         if (i == corrupt_idx) sent[i] = sent[i] ^ mask;
         send_word(sent[i], i == last_idx);
      end
   endtask

   task automatic check_a_zero(input string tag);
      check({tag, "_ready"},    32'(a_ready),   32'd0);
      check({tag, "_busy"},     32'(a_busy),    32'd0);
      check({tag, "_done"},     32'(a_done),    32'd0);
      check({tag, "_pass"},     32'(a_pass),    32'd0);
      check({tag, "_timeout"},  32'(a_timeout), 32'd0);
      check({tag, "_err_cnt"},  32'(a_err_cnt), 32'd0);
      check({tag, "_word_cnt"}, 32'(a_word_cnt), 32'd0);
      check({tag, "_fidx"},     32'(a_first_idx), 32'd0);
      check({tag, "_fdata"},    a_first_data,   32'd0);
   endtask

   initial begin
      int n;
      int c;
      int w;

      // reset
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      check_a_zero("reset_a");
      check("reset_b_ready", 32'(b_ready), 32'd0);
      check("reset_b_done",  32'(b_done),  32'd0);
      check("reset_b_word",  32'(b_word_cnt), 32'd0);

      // Clean stream: done/pass visible right after the 8th accepting edge.
      pulse_start(0);
      check("clean_busy", 32'(a_busy), 32'd1);
      run_stream(7, -1, 32'h0, 7);
      check("clean_word7", 32'(a_word_cnt), 32'd7);
      check("clean_not_done", 32'(a_done), 32'd0);
      sent[7] = exp_q.pop_front();
      send_word(sent[7], 1'b1);
      check("clean_done",    32'(a_done),     32'd1);
      check("clean_pass",    32'(a_pass),     32'd1);
      check("clean_word",    32'(a_word_cnt), 32'd8);
      check("clean_err",     32'(a_err_cnt),  32'd0);
      check("clean_busy_lo", 32'(a_busy),     32'd0);
      check("clean_timeout", 32'(a_timeout),  32'd0);

      // Words after DONE are ignored.
      in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("post_done_ready", 32'(a_ready),    32'd0);
      check("post_done_word",  32'(a_word_cnt), 32'd8);
      check("post_done_err",   32'(a_err_cnt),  32'd0);
      in_valid = 1'b0; in_last = 1'b0;

      // Single corrupt word 3.
      pulse_start(0);
      check("restart_done", 32'(a_done),     32'd0);
      check("restart_pass", 32'(a_pass),     32'd0);
      check("restart_word", 32'(a_word_cnt), 32'd0);
      run_stream(8, 3, 32'h1, 7);
      check("corrupt_err",   32'(a_err_cnt),   32'd1);
      check("corrupt_fidx",  32'(a_first_idx), 32'd3);
      check("corrupt_fdata", a_first_data,     sent[3]);
      check("corrupt_done",  32'(a_done),      32'd1);
      check("corrupt_pass",  32'(a_pass),      32'd0);

      // Framing: last on word 5, missing on word 7.
      pulse_start(0);
      run_stream(8, -1, 32'h0, 5);
      check("frame_err",   32'(a_err_cnt),   32'd2);
      check("frame_fidx",  32'(a_first_idx), 32'd5);
      check("frame_fdata", a_first_data,     sent[5]);
      check("frame_pass",  32'(a_pass),      32'd0);
      check("frame_word",  32'(a_word_cnt),  32'd8);

      // Final word with both a data and a framing error counts once.
      pulse_start(0);
      run_stream(8, 7, 32'h8000_0000, -1);
      check("both_err",   32'(a_err_cnt),   32'd1);
      check("both_fidx",  32'(a_first_idx), 32'd7);
      check("both_fdata", a_first_data,     sent[7]);
      check("both_done",  32'(a_done),      32'd1);

      // Watchdog: done rises on the 20th edge after the 2nd accepting edge.
      pulse_start(0);
      run_stream(2, -1, 32'h0, -1);
      n = 0;
      while (!a_done && n < 40) begin
         @(posedge clk); #1;
         n++;
      end
      check("wd_latency", 32'(n),          32'd20);
      check("wd_timeout", 32'(a_timeout),  32'd1);
      check("wd_done",    32'(a_done),     32'd1);
      check("wd_pass",    32'(a_pass),     32'd0);
      check("wd_word",    32'(a_word_cnt), 32'd2);
      check("wd_busy",    32'(a_busy),     32'd0);

      // Reset mid-run, with start held in the same cycle.
      pulse_start(0);
      check("fail_restart_timeout", 32'(a_timeout), 32'd0);
      run_stream(3, 1, 32'h1, -1);
      check("midrun_err", 32'(a_err_cnt), 32'd1);
      rst = 1'b1; start_a = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start_a = 1'b0;
      check_a_zero("midrun_rst");
      pulse_start(0);
      run_stream(8, -1, 32'h0, 7);
      check("after_rst_done", 32'(a_done),    32'd1);
      check("after_rst_pass", 32'(a_pass),    32'd1);
      check("after_rst_err",  32'(a_err_cnt), 32'd0);

      // Back-pressure on dut_b with valid held high.
      pulse_start(1);
      fill_q();
      in_valid = 1'b1;
      in_data  = exp_q[0];
      in_last  = 1'b0;
      w = 0;
      c = 0;
      while (w < 8 && c < 30) begin
         check("bp_ready_pattern", 32'(b_ready), 32'((c % 4) != 3));
         if (b_ready) begin
            void'(exp_q.pop_front());
            w++;
         end
         @(posedge clk); #1;
         c++;
         if (w < 8) begin
            in_data = exp_q[0];
            in_last = (w == 7);
         end
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      check("bp_cycles", 32'(c),          32'd10);
      check("bp_done",   32'(b_done),     32'd1);
      check("bp_pass",   32'(b_pass),     32'd1);
      check("bp_word",   32'(b_word_cnt), 32'd8);
      check("bp_err",    32'(b_err_cnt),  32'd0);

      // report
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
